bsg_subtractor_borrow_serial: RTL and testbench

BSG_SUBTRACTOR_BORROW_SERIAL -- requirements
Module: bsg_subtractor_borrow_serial

---
 rtl/bsg_subtractor_borrow_serial.sv | 136 +++++++++++++
 tb/tb_bsg_subtractor_borrow_serial.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_subtractor_borrow_serial.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_subtractor_borrow_serial
//  Purpose  : Chunk-serial unsigned subtractor o = a - b - bin, chunk_p bits
//             per cycle. Define BSG_SUBTRACTOR_BORROW_OUT_EN for borrow_o.
//  Revision : 1.0
// ============================================================================
module bsg_subtractor_borrow_serial #(
    parameter int width_p = 32,
    parameter int chunk_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] a_i,
    input  logic [width_p-1:0] b_i,
    input  logic               bin_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] o,
    output logic               v_o,
`ifdef BSG_SUBTRACTOR_BORROW_OUT_EN
    output logic               borrow_o,
`endif
    input  logic               yumi_i
);

    localparam int SAFE_CHUNK = (chunk_p < 1) ? 1 : chunk_p;
    localparam int NUM_CHUNKS = ((width_p / SAFE_CHUNK) < 1) ? 1 : (width_p / SAFE_CHUNK);
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

    generate
        if ((chunk_p < 1) || (width_p < 1) || ((width_p % SAFE_CHUNK) != 0)) begin : g_param_check
            $error("bsg_subtractor_borrow_serial: width_p must be a nonzero multiple of chunk_p >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [width_p-1:0] a_q, a_d;
    logic [width_p-1:0] b_q, b_d;
    logic [width_p-1:0] o_q, o_d;
    logic               borrow_q, borrow_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    int unsigned        bit_off;
    logic [chunk_p:0]   slice_diff;
    logic               last_slice;

    // One extra bit on the slice difference: its MSB is the borrow out of the slice.
    assign bit_off    = cnt_q * chunk_p;
    assign slice_diff = {1'b0, a_q[bit_off +: chunk_p]}
                      - {1'b0, b_q[bit_off +: chunk_p]}
                      - {{chunk_p{1'b0}}, borrow_q};
    assign last_slice = (cnt_q == LAST_CNT);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        o_d      = o_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (v_i) begin
                    state_d  = BUSY;
                    a_d      = a_i;
                    b_d      = b_i;
                    borrow_d = bin_i;
                    cnt_d    = '0;
                end
            end
            BUSY: begin
                o_d[bit_off +: chunk_p] = slice_diff[chunk_p-1:0];
                borrow_d                = slice_diff[chunk_p];
                cnt_d                   = cnt_q + 1'b1;
                if (last_slice) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (yumi_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            o_q      <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            o_q      <= o_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef BSG_SUBTRACTOR_BORROW_OUT_EN
    logic borrow_out_q;

    // Captured only on the final slice so it stays frozen alongside o.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            borrow_out_q <= 1'b0;
        end else if ((state_q == BUSY) && last_slice) begin
            borrow_out_q <= slice_diff[chunk_p];
        end
    end

    assign borrow_o = borrow_out_q;
`endif

    assign ready_o = (state_q == IDLE);
    assign v_o     = (state_q == DONE);
    assign o       = o_q;

endmodule
`default_nettype wire

// File: tb/tb_bsg_subtractor_borrow_serial.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bsg_subtractor_borrow_serial
//  Purpose  : Self-checking bench for bsg_subtractor_borrow_serial (32/8 and
//             32/32 configurations) against an arithmetic reference model.
//  Revision : 1.0
// ============================================================================
module tb_bsg_subtractor_borrow_serial;

    localparam int W   = 32;
    localparam int C   = 8;
    localparam int LAT = W / C;

    logic         clk = 1'b0;
    logic         reset_i;
    logic [W-1:0] a_i, b_i;
    logic         bin_i, v_i, yumi_i;
    logic         ready_o, v_o;
    logic [W-1:0] o;
    logic         v1_i, yumi1_i, ready1_o, v1_o;
    logic [W-1:0] o1;
`ifdef BSG_SUBTRACTOR_BORROW_OUT_EN
    logic         borrow_o, borrow1_o;
`endif

    int checks = 0;
    int errors = 0;
    logic [W:0] last_exp;

    always #5 clk = ~clk;

    bsg_subtractor_borrow_serial #(.width_p(W), .chunk_p(C)) u_dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .bin_i   (bin_i),
        .v_i     (v_i),
        .ready_o (ready_o),
        .o       (o),
        .v_o     (v_o),
`ifdef BSG_SUBTRACTOR_BORROW_OUT_EN
        .borrow_o(borrow_o),
`endif
        .yumi_i  (yumi_i)
    );

    bsg_subtractor_borrow_serial #(.width_p(W), .chunk_p(W)) u_dut_full (
        .clk_i   (clk),
        .reset_i (reset_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .bin_i   (bin_i),
        .v_i     (v1_i),
        .ready_o (ready1_o),
        .o       (o1),
        .v_o     (v1_o),
`ifdef BSG_SUBTRACTOR_BORROW_OUT_EN
        .borrow_o(borrow1_o),
`endif
        .yumi_i  (yumi1_i)
    );

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: {borrow, difference} straight from unsigned arithmetic.
    function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        logic [63:0] full;
        logic        brw;
        full = {32'd0, a} - {32'd0, b} - {63'd0, bin};
        brw  = ({32'd0, a} < ({32'd0, b} + {63'd0, bin}));
        return {brw, full[W-1:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag, input logic [W:0] exp);
        check_value({tag, "_o"}, {32'd0, o}, {32'd0, exp[W-1:0]});
`ifdef BSG_SUBTRACTOR_BORROW_OUT_EN
        check_value({tag, "_borrow"}, {63'd0, borrow_o}, {63'd0, exp[W]});
`endif
    endtask

    // Issues one op on u_dut, checks latency and result; leaves the DUT in DONE.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        int n;
        n = 0;
        while (!ready_o && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) check_value({tag, "_ready_timeout"}, 64'd0, 64'd1);
        last_exp = ref_sub(a, b, bin);
        a_i = a; b_i = b; bin_i = bin; v_i = 1'b1;
        step();
        v_i = 1'b0; a_i = $urandom; b_i = $urandom; bin_i = 1'b1;
        n = 0;
        while (!v_o && n < 20) begin
            step();
            n++;
        end
        check_value({tag, "_latency"}, 64'(n), 64'(LAT));
        check_result(tag, last_exp);
    endtask

    task automatic consume(input string tag);
        yumi_i = 1'b1;
        step();
        yumi_i = 1'b0;
        check_value({tag, "_idle"}, {62'd0, ready_o, v_o}, 64'b10);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb;
        logic [W-1:0] held;
        logic [W:0]   e;
        logic [W:0]   expq[$];
        int           n, accepts, results, last_acc, dly;

        reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0; v1_i = 1'b0; yumi1_i = 1'b0;
        a_i = '0; b_i = '0; bin_i = 1'b0;
        repeat (3) step();
        reset_i = 1'b0;
        check_value("reset_state", {31'd0, ready_o, v_o, o}, {31'd0, 1'b1, 1'b0, 32'd0});
`ifdef BSG_SUBTRACTOR_BORROW_OUT_EN
        check_value("reset_borrow", {63'd0, borrow_o}, 64'd0);
`endif

        run_op("simple", 32'd5, 32'd3, 1'b0);
        check_value("simple_exact", {32'd0, o}, 64'h2);
        consume("simple");
        run_op("zero_minus_one", 32'd0, 32'd1, 1'b0);
        check_value("zmo_exact", {32'd0, o}, 64'hFFFF_FFFF);
        consume("zmo");
        run_op("zero_bin", 32'd0, 32'd0, 1'b1);
        consume("zero_bin");
        run_op("two_slice", 32'h0001_0000, 32'h0000_0001, 1'b0);
        check_value("two_slice_exact", {32'd0, o}, 64'h0000_FFFF);
        consume("two_slice");

        // Hold off the consumer; result must stay frozen and v_i be ignored.
        run_op("hold", 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
        held = o;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                a_i = 32'h1111_1111; b_i = 32'h2222_2222; v_i = 1'b1;
            end
            step();
            v_i = 1'b0;
            check_value("hold_stable", {30'd0, ready_o, v_o, o}, {30'd0, 1'b0, 1'b1, held});
        end
        consume("hold");
        step();
        check_value("hold_no_accept", {62'd0, ready_o, v_o}, 64'b10);

        // Reset in the middle of BUSY, with v_i high during reset.
        a_i = 32'hCAFE_0001; b_i = 32'h0000_0FFF; bin_i = 1'b0; v_i = 1'b1;
        step();
        v_i = 1'b0;
        step(); step();
        reset_i = 1'b1; v_i = 1'b1;
        step();
        check_value("midbusy_reset", {31'd0, ready_o, v_o, o}, {31'd0, 1'b1, 1'b0, 32'd0});
        step();
        reset_i = 1'b0; v_i = 1'b0;
        step();
        check_value("reset_no_accept", {62'd0, ready_o, v_o}, 64'b10);
        run_op("seven", 32'd7, 32'd7, 1'b0);
        consume("seven");

        // Randomized ops with random consumer delay.
        for (int k = 0; k < 30; k++) begin
            ra = $urandom; rb = $urandom;
            if (k % 4 == 0) rb = ra;
            run_op("rand", ra, rb, 1'($urandom_range(0, 1)));
            dly = $urandom_range(0, 3);
            for (int d = 0; d < dly; d++) begin
                step();
                check_result("rand_wait", last_exp);
            end
            consume("rand");
        end

        // Back-to-back: v_i and yumi_i held high, operands churn every cycle.
        accepts = 0; results = 0; last_acc = -1;
        yumi_i = 1'b1; v_i = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            a_i = $urandom; b_i = $urandom; bin_i = 1'($urandom_range(0, 1));
            if (accepts == 20) v_i = 1'b0;
            if (ready_o && v_i) begin
                expq.push_back(ref_sub(a_i, b_i, bin_i));
                if (last_acc >= 0) check_value("b2b_spacing", 64'(cyc - last_acc), 64'd6);
                last_acc = cyc;
                accepts++;
            end
            if (v_o) begin
                if (expq.size() == 0) begin
                    check_value("b2b_extra_result", 64'd1, 64'd0);
                end else begin
                    e = expq.pop_front();
                    check_result("b2b", e);
                end
                results++;
            end
            step();
            if (accepts == 20 && expq.size() == 0) break;
        end
        yumi_i = 1'b0; v_i = 1'b0;
        check_value("b2b_results", 64'(results), 64'd20);
        check_value("b2b_pending", 64'(expq.size()), 64'd0);

        // Single-chunk configuration: latency of one cycle.
        for (int k = 0; k < 4; k++) begin
            ra = (k == 0) ? 32'd0 : $urandom;
            rb = (k == 0) ? 32'd1 : $urandom;
            e  = ref_sub(ra, rb, 1'(k == 2));
            a_i = ra; b_i = rb; bin_i = 1'(k == 2); v1_i = 1'b1;
            step();
            v1_i = 1'b0;
            n = 0;
            while (!v1_o && n < 10) begin
                step();
                n++;
            end
            check_value("full_latency", 64'(n), 64'd1);
            check_value("full_o", {32'd0, o1}, {32'd0, e[W-1:0]});
`ifdef BSG_SUBTRACTOR_BORROW_OUT_EN
            check_value("full_borrow", {63'd0, borrow1_o}, {63'd0, e[W]});
`endif
            yumi1_i = 1'b1;
            step();
            yumi1_i = 1'b0;
            check_value("full_idle", {62'd0, ready1_o, v1_o}, 64'b10);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
